data_mem_stage: RTL and testbench

DATA_MEM_STAGE -- requirements
Module: data_mem_stage

---
 rtl/data_mem_stage.sv | 195 +++++++++++++++++++
 tb/tb_data_mem_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_stage.sv
// ============================================================================
// Module   : data_mem_stage
// Purpose  : Pipeline MEM stage. Forwards non-memory instructions to WB in one
//            cycle, performs word/byte stores into a MEM_WORDS x 16-bit
//            big-endian byte-addressed memory, and services LW/LBU with a
//            registered read that takes two cycles (one stall cycle).
//            Bad accesses (misaligned word access or address beyond the
//            memory) set a sticky fault flag, suppress the write and return
//            zero load data; the instruction is still forwarded.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous reset, active low
//            instr_in  - instruction from EX/MEM, opcode in [15:12]
//            result_in - ALU result; [15:0] is the byte address for memory ops
//            op1_in    - store data
//            valid_in  - EX/MEM inputs carry a live instruction
//            stall     - hold EX/MEM contents (high during the load wait cycle)
//            wb_instr  - registered instruction to WB
//            wb_data   - registered result to WB
//            wb_valid  - wb_instr/wb_data are live
//            fault     - sticky access-fault flag
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_stage #(
  parameter int MEM_WORDS = 32,
  parameter int ADDR_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic [31:0] result_in,
  input  logic [15:0] op1_in,
  input  logic        valid_in,
  output logic        stall,
  output logic [15:0] wb_instr,
  output logic [31:0] wb_data,
  output logic        wb_valid,
  output logic        fault
);

  localparam logic [3:0]  c_op_lw     = 4'b1000;
  localparam logic [3:0]  c_op_sb     = 4'b1001;
  localparam logic [3:0]  c_op_lbu    = 4'b1010;
  localparam logic [3:0]  c_op_sw     = 4'b1011;
  localparam logic [14:0] c_mem_words = 15'(MEM_WORDS);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_mem [MEM_WORDS];

  logic        r_stall;
  logic [15:0] r_wb_instr;
  logic [31:0] r_wb_data;
  logic        r_wb_valid;
  logic        r_fault;
  logic [15:0] r_ld_instr;
  logic [15:0] r_ld_data;

  // Decode of the live EX/MEM inputs
  logic [3:0]        w_opc;
  logic [15:0]       w_addr;
  logic [ADDR_W-1:0] w_idx;
  logic              w_is_lw, w_is_sb, w_is_lbu, w_is_sw;
  logic              w_is_load, w_is_store;
  logic              w_bad;
  logic [15:0]       w_rd_word;
  logic [15:0]       w_rd_data;

  assign w_opc      = instr_in[15:12];
  assign w_addr     = result_in[15:0];
  assign w_idx      = w_addr[ADDR_W:1];
  assign w_is_lw    = (w_opc == c_op_lw);
  assign w_is_sb    = (w_opc == c_op_sb);
  assign w_is_lbu   = (w_opc == c_op_lbu);
  assign w_is_sw    = (w_opc == c_op_sw);
  assign w_is_load  = w_is_lw | w_is_lbu;
  assign w_is_store = w_is_sw | w_is_sb;

  // Word accesses must be even; any access must fall inside the memory.
  assign w_bad = (w_addr[15:1] >= c_mem_words) | (w_addr[0] & (w_is_lw | w_is_sw));

  // Load data is resolved from the array contents at the capture edge, so a
  // store committed on the previous edge is already visible.
  assign w_rd_word = r_mem[w_idx];
  always_comb begin
    w_rd_data = 16'h0000;
    if (!w_bad) begin
      if (w_is_lw)        w_rd_data = w_rd_word;
      else if (w_addr[0]) w_rd_data = {8'h00, w_rd_word[7:0]};
      else                w_rd_data = {8'h00, w_rd_word[15:8]};
    end
  end

  // Next-state / next-output logic
  logic        w_stall_nxt;
  logic [15:0] w_wb_instr_nxt;
  logic [31:0] w_wb_data_nxt;
  logic        w_wb_valid_nxt;
  logic        w_fault_set;
  logic        w_capture;
  logic        w_we_hi, w_we_lo;
  logic [15:0] w_wdata;

  always_comb begin
    w_state_nxt    = r_state;
    w_stall_nxt    = 1'b0;
    w_wb_instr_nxt = r_wb_instr;
    w_wb_data_nxt  = r_wb_data;
    w_wb_valid_nxt = 1'b0;
    w_fault_set    = 1'b0;
    w_capture      = 1'b0;
    w_we_hi        = 1'b0;
    w_we_lo        = 1'b0;
    w_wdata        = w_is_sw ? op1_in : {op1_in[7:0], op1_in[7:0]};

    case (r_state)
      IDLE: begin
        if (valid_in) begin
          w_fault_set = (w_is_load | w_is_store) & w_bad;
          if (w_is_load) begin
            w_capture   = 1'b1;
            w_stall_nxt = 1'b1;
            w_state_nxt = LOAD_WAIT;
          end else begin
            w_wb_instr_nxt = instr_in;
            w_wb_data_nxt  = result_in;
            w_wb_valid_nxt = 1'b1;
            if (w_is_store && !w_bad) begin
              // SB picks a single big-endian lane; SW writes both.
              w_we_hi = w_is_sw | ~w_addr[0];
              w_we_lo = w_is_sw |  w_addr[0];
            end
          end
        end
      end
      LOAD_WAIT: begin
        // EX/MEM is held upstream; its contents are ignored here.
        w_wb_instr_nxt = r_ld_instr;
        w_wb_data_nxt  = {16'h0000, r_ld_data};
        w_wb_valid_nxt = 1'b1;
        w_state_nxt    = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_stall    <= 1'b0;
      r_wb_instr <= 16'h0000;
      r_wb_data  <= 32'h0000_0000;
      r_wb_valid <= 1'b0;
      r_fault    <= 1'b0;
      r_ld_instr <= 16'h0000;
      r_ld_data  <= 16'h0000;
    end else begin
      r_state    <= w_state_nxt;
      r_stall    <= w_stall_nxt;
      r_wb_instr <= w_wb_instr_nxt;
      r_wb_data  <= w_wb_data_nxt;
      r_wb_valid <= w_wb_valid_nxt;
      r_fault    <= r_fault | w_fault_set;
      if (w_capture) begin
        r_ld_instr <= instr_in;
        r_ld_data  <= w_rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem <= '{default: 16'h0000};
    end else begin
      if (w_we_hi) r_mem[w_idx][15:8] <= w_wdata[15:8];
      if (w_we_lo) r_mem[w_idx][7:0]  <= w_wdata[7:0];
    end
  end

  assign stall    = r_stall;
  assign wb_instr = r_wb_instr;
  assign wb_data  = r_wb_data;
  assign wb_valid = r_wb_valid;
  assign fault    = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_stage.sv
// ============================================================================
// Module   : tb_data_mem_stage
// Purpose  : Self-checking bench for data_mem_stage. A driver issues directed
//            and random instructions and pushes the expected WB response
//            (with the cycle it must appear in) into a queue; a monitor on
//            the falling edge pops and compares whenever wb_valid is high and
//            checks stall/fault/hold behaviour every cycle. The reference
//            memory is a flat big-endian byte array.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_stage;

  localparam logic [3:0] c_lw  = 4'b1000;
  localparam logic [3:0] c_sb  = 4'b1001;
  localparam logic [3:0] c_lbu = 4'b1010;
  localparam logic [3:0] c_sw  = 4'b1011;
  localparam logic [3:0] c_add = 4'b0001;
  localparam int         c_never = 1 << 30;

  logic        clk;
  logic        rst_n;
  logic [15:0] instr_in;
  logic [31:0] result_in;
  logic [15:0] op1_in;
  logic        valid_in;
  logic        stall;
  logic [15:0] wb_instr;
  logic [31:0] wb_data;
  logic        wb_valid;
  logic        fault;

  data_mem_stage #(.MEM_WORDS(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .instr_in  (instr_in),
    .result_in (result_in),
    .op1_in    (op1_in),
    .valid_in  (valid_in),
    .stall     (stall),
    .wb_instr  (wb_instr),
    .wb_data   (wb_data),
    .wb_valid  (wb_valid),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mb [64];
  int          cyc       = 0;
  int          stall_due = -1;
  int          fault_cyc = c_never;
  logic [15:0] last_instr = 16'h0;
  logic [31:0] last_data  = 32'h0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < 64; i++) mb[i] = 8'h00;
    stall_due  = -1;
    fault_cyc  = c_never;
    last_instr = 16'h0;
    last_data  = 32'h0;
  endtask

  // ---------------------------------------------------------------- monitor
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_stall",    {31'h0, stall},    32'h0);
      chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
      chk("rst_fault",    {31'h0, fault},    32'h0);
      chk("rst_wb_instr", {16'h0, wb_instr}, 32'h0);
      chk("rst_wb_data",  wb_data,           32'h0);
    end else begin
      chk("stall", {31'h0, stall}, {31'h0, (cyc == stall_due)});
      chk("fault", {31'h0, fault}, {31'h0, (cyc >= fault_cyc)});
      if (wb_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_wb_valid", 32'h1, 32'h0);
        end else begin
          mon_e = q.pop_front();
          chk("wb_instr",   {16'h0, wb_instr}, {16'h0, mon_e.instr});
          chk("wb_data",    wb_data,           mon_e.data);
          chk("wb_latency", cyc,               mon_e.due);
          last_instr = mon_e.instr;
          last_data  = mon_e.data;
        end
      end else begin
        chk("hold_wb_instr", {16'h0, wb_instr}, {16'h0, last_instr});
        chk("hold_wb_data",  wb_data,           last_data);
        if (q.size() != 0 && q[0].due <= cyc)
          chk("missing_wb_valid", 32'h0, 32'h1);
      end
    end
  end

  // ----------------------------------------------------------------- driver
  // All driver tasks start and end at a falling edge.
  task automatic issue(input logic [3:0] opc, input logic [31:0] res, input logic [15:0] d);
    logic [15:0] ins;
    logic [15:0] a;
    int          ia;
    bit          is_mem, is_load, bad;
    exp_t        e;
    ins = {opc, 12'($urandom)};
    a   = res[15:0];
    ia  = int'(a);
    instr_in  = ins;
    result_in = res;
    op1_in    = d;
    valid_in  = 1'b1;
    is_mem  = (opc == c_lw) || (opc == c_sw) || (opc == c_sb) || (opc == c_lbu);
    is_load = (opc == c_lw) || (opc == c_lbu);
    bad = (ia >= 64) || (a[0] && (opc == c_lw || opc == c_sw));
    if (is_mem && bad && fault_cyc > cyc + 1) fault_cyc = cyc + 1;
    e.instr = ins;
    if (is_load) begin
      if (bad)              e.data = 32'h0;
      else if (opc == c_lw) e.data = {16'h0, mb[ia], mb[ia + 1]};
      else                  e.data = {24'h0, mb[ia]};
      e.due     = cyc + 2;
      stall_due = cyc + 1;
    end else begin
      if (!bad && opc == c_sw) begin
        mb[ia]     = d[15:8];
        mb[ia + 1] = d[7:0];
      end else if (!bad && opc == c_sb) begin
        mb[ia] = d[7:0];
      end
      e.data = res;
      e.due  = cyc + 1;
    end
    q.push_back(e);
    @(negedge clk);
    if (is_load) begin
      // Wait cycle: anything on the inputs now must be ignored.
      instr_in  = 16'($urandom);
      result_in = $urandom;
      op1_in    = 16'($urandom);
      valid_in  = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic idle();
    valid_in  = 1'b0;
    instr_in  = {c_sw, 12'($urandom)};
    result_in = {16'($urandom), 16'($urandom_range(0, 63))};
    op1_in    = 16'($urandom);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    valid_in = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0]  r_opc;
  logic [15:0] r_addr;
  int          pick;

  initial begin
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    instr_in  = 16'h0;
    result_in = 32'h0;
    op1_in    = 16'h0;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Store then load of the same word
    issue(c_sw, 32'h0000_0004, 16'hBEEF);
    issue(c_lw, 32'h0000_0004, 16'h1111);
    // Byte store onto a word, then both byte lanes
    issue(c_sw, 32'h0000_0006, 16'hBEEF);
    issue(c_sb, 32'h0000_0007, 16'h0012);
    issue(c_lbu, 32'h0000_0006, 16'h0);
    issue(c_lbu, 32'h0000_0007, 16'h0);
    // Plain ALU instruction
    issue(c_add, 32'h0003_0005, 16'h0);
    idle();
    // Back-to-back loads followed by ALU op
    issue(c_lw, 32'h0000_0006, 16'h0);
    issue(c_lw, 32'h0000_0004, 16'h0);
    issue(c_add, 32'h1234_5678, 16'h0);
    // Faulting accesses; memory must be untouched (0x40 would alias word 0)
    issue(c_lw, 32'h0000_0003, 16'h0);
    issue(c_sw, 32'h0000_0040, 16'hDEAD);
    repeat (10) idle();
    issue(c_lw, 32'h0000_0000, 16'h0);
    issue(c_lw, 32'h0000_0004, 16'h0);

    // Reset in the middle of a load wait cycle
    instr_in  = {c_lw, 12'h0AB};
    result_in = 32'h0000_0004;
    valid_in  = 1'b1;
    stall_due = cyc + 1;
    @(negedge clk);
    #1 rst_n = 1'b0;
    model_clear();
    valid_in = 1'b0;
    #1;
    chk("midload_rst_stall",    {31'h0, stall},    32'h0);
    chk("midload_rst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("midload_rst_fault",    {31'h0, fault},    32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(c_lw, 32'h0000_0004, 16'h0);
    issue(c_lbu, 32'h0000_0007, 16'h0);
    repeat (2) idle();

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      pick = $urandom_range(0, 99);
      if (pick < 4) begin
        do_reset();
      end else if (pick < 14) begin
        idle();
      end else begin
        case ($urandom_range(0, 5))
          0: r_opc = c_lw;
          1: r_opc = c_sw;
          2: r_opc = c_sb;
          3: r_opc = c_lbu;
          default: begin
            r_opc = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) r_opc = 4'($urandom_range(12, 15));
          end
        endcase
        if ($urandom_range(0, 19) == 0) r_addr = 16'($urandom);
        else                            r_addr = 16'($urandom_range(0, 63));
        if ((r_opc == c_lw || r_opc == c_sw) && $urandom_range(0, 4) != 0)
          r_addr[0] = 1'b0;
        issue(r_opc, {16'($urandom), r_addr}, 16'($urandom));
      end
    end

    repeat (4) idle();
    chk("queue_drained", q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
